vec_mult_ctrl: RTL
==================

Name: vec_mult_ctrl

Overview:
- Sequencer that streams two signed operand vectors from dual-read operand RAM through one BITS-wide fixed-point multiplier and writes the element-wise products to a destination RAM.
- Sits between the host register file (start, length and base addresses) and the vector memories. It is the element-wise multiply engine of the accelerator.
- Sustains 1 element/cycle and honours write back-pressure.

Parameters:
- BITS, 8, operand/result width (signed two's complement).
- OUT_SHIFT, 0, arithmetic right shift applied to the 2*BITS product before narrowing to BITS.
- ADDR_W, 8, memory address width; vector length 0..2^ADDR_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle command strobe; sampled only in IDLE.
- len  in  ADDR_W+1  element count, latched at start.
- a_base  in  ADDR_W  operand A start address, latched at start.
- b_base  in  ADDR_W  operand B start address, latched at start.
- d_base  in  ADDR_W  destination start address, latched at start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  1-cycle pulse at command completion.
- rd_en  out  1  operand read strobe; data returns exactly 1 cycle later.
- rd_addr_a  out  ADDR_W  A read address.
- rd_addr_b  out  ADDR_W  B read address.
- rd_data_a  in  BITS  A read data.
- rd_data_b  in  BITS  B read data.
- wr_en  out  1  result valid.
- wr_addr  out  ADDR_W  result address.
- wr_data  out  BITS  result.
- wr_ready  in  1  sink accepts; transfer when wr_en && wr_ready.

Behaviour:
- Reset: FSM=IDLE; busy, done, rd_en and wr_en are 0; all address and data outputs are 0; counters cleared. Reset mid-command aborts it with no done pulse and no further writes.
- FSM: IDLE -> RUN on start with len!=0. IDLE -> DONE on start with len==0, giving done the next cycle with no reads or writes. RUN -> DRAIN after the len-th read is issued. DRAIN -> DONE when the last write handshakes. DONE -> IDLE unconditionally after 1 cycle, with done=1 in DONE.
- busy is 1 in RUN, DRAIN and DONE. start is ignored when not in IDLE.
- Read issue: element i reads a_base+i and b_base+i. Addresses wrap modulo 2^ADDR_W. No read is issued when the skid register would overflow, i.e. when the output register and the skid register are both full, or the output register is full, wr_ready=0 and a read is in flight.
- Datapath stage 1 (combinational on returning data): P_full = signed(rd_data_a) * signed(rd_data_b), 2*BITS bits. R = P_full >>> OUT_SHIFT. Result = R[BITS-1:0], truncation/wrap.
- Datapath stage 2 (registered output): drives wr_en/wr_addr/wr_data. wr_addr = d_base+i, wrapping modulo 2^ADDR_W.
- Skid: one-entry skid register holds returning data when the output register is stalled. Order is strictly preserved.
- Stall rule: wr_data and wr_addr stay stable while wr_en && !wr_ready.
- Latency: start sampled at cycle 0; rd_en first at cycle 1; first wr_en at cycle 3. With wr_ready=1 throughout, writes occur on consecutive cycles and done is asserted at cycle len+3.
- len == 2^ADDR_W is legal: every address is touched once.
- Overlapping source and destination ranges are not hazard-checked; reads always precede the corresponding write.

Optional Feature:
- Macro VEC_MULT_SAT_EN.
- Defined: R is saturated to [-2^(BITS-1), 2^(BITS-1)-1] before narrowing, and a sticky output sat_flag (1 bit) sets on any clipped element. sat_flag clears at start acceptance and resets to 0.
- Undefined: plain truncation, and the sat_flag port does not exist.

Decomposition:
- Package vec_pkg: state enum (IDLE, RUN, DRAIN, DONE), and a sat_mul function (shift, optional clip, narrow) parameterised via BITS/OUT_SHIFT arguments.
- The arithmetic is the team's single_multiplier module, instantiated once with BITS and OUT_SHIFT. The controller contains only the FSM, counters, skid and output registers.

Test Plan:
- BITS=8, OUT_SHIFT=0, len=4, A={1,2,-3,127}, B={5,-6,7,2}, wr_ready=1 -> writes {5,-12,-21,-2 (0xFE)} to d_base..d_base+3 on cycles 3..6; done at cycle 7.
- OUT_SHIFT=4, A=0x40, B=0x40 (product 0x1000) -> wr_data=0x00. With VEC_MULT_SAT_EN: wr_data=0x7F and sat_flag=1.
- len=6 with wr_ready toggling 1,0,0,1,0,1,... -> exactly 6 writes, in order, with no duplicate or lost element; wr_data stable while stalled.
- a_base=0xFE, d_base=0xFF, len=3 (ADDR_W=8) -> reads at 0xFE, 0xFF, 0x00; writes at 0xFF, 0x00, 0x01.
- len=0 -> no rd_en or wr_en; done 1 cycle after start. A start pulse during busy -> ignored, and the latched parameters are unchanged.
- rst_n pulled low at cycle 4 of a len=8 run -> all outputs are 0 immediately; no done; a new start after release completes normally.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared state encoding and arithmetic helpers for the vector multiply engine.
// Saturation behaviour is selected by the VEC_MULT_SAT_EN macro in the users of this package.
package vec_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_t;

    // Shift and optionally clip a sign-extended product; the caller narrows to its own width.
    function automatic logic [63:0] sat_mul(input logic signed [63:0] prod,
                                            input int unsigned        bits,
                                            input int unsigned        shift,
                                            input logic               sat_en);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = prod >>> shift;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (sat_en && (r > hi)) begin
            r = hi;
        end else if (sat_en && (r < lo)) begin
            r = lo;
        end
        return r;
    endfunction

    function automatic logic mul_clips(input logic signed [63:0] prod,
                                       input int unsigned        bits,
                                       input int unsigned        shift);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = prod >>> shift;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        return (r > hi) || (r < lo);
    endfunction

endpackage

// File: rtl/single_multiplier.sv
// Signed BITS x BITS multiplier with arithmetic output shift and narrowing.
// With VEC_MULT_SAT_EN defined the result is clipped and a clip indication is produced.
module single_multiplier
    import vec_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
`ifdef VEC_MULT_SAT_EN
    output logic            clip,
`endif
    output logic [BITS-1:0] result
);

    logic signed [2*BITS-1:0] prod;
    logic signed [63:0]       prod_ext;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = 64'(prod);

`ifdef VEC_MULT_SAT_EN
    localparam logic SatEn = 1'b1;
    assign clip = mul_clips(prod_ext, BITS, OUT_SHIFT);
`else
    localparam logic SatEn = 1'b0;
`endif

    assign result = BITS'(sat_mul(prod_ext, BITS, OUT_SHIFT, SatEn));

endmodule

// File: rtl/vec_mult_ctrl.sv
// Element-wise vector multiply sequencer: operand reads, one multiplier, skid-buffered writes.
// Optional VEC_MULT_SAT_EN adds result saturation and a sticky sat_flag output.
module vec_mult_ctrl
    import vec_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned OUT_SHIFT = 0,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] d_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [BITS-1:0]   rd_data_a,
    input  logic [BITS-1:0]   rd_data_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BITS-1:0]   wr_data,
    input  logic              wr_ready
`ifdef VEC_MULT_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam logic [ADDR_W:0] One = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d, ld_cnt_q, ld_cnt_d, wr_cnt_q, wr_cnt_d;
    logic              in_flight_q, in_flight_d;
    logic              skid_valid_q, skid_valid_d;
    logic [BITS-1:0]   skid_data_q, skid_data_d;
    logic              out_valid_q, out_valid_d;
    logic [BITS-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [BITS-1:0]   prod;
    logic              accept, out_fire, out_free, rd_block, rd_go, last_rd, last_wr;

`ifdef VEC_MULT_SAT_EN
    logic clip;
    logic sat_q, sat_d;
`endif

    single_multiplier #(
        .BITS      (BITS),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mul (
        .a      (rd_data_a),
`ifdef VEC_MULT_SAT_EN
        .clip   (clip),
`endif
        .b      (rd_data_b),
        .result (prod)
    );

    assign accept   = (state_q == StIdle) && start;
    assign out_fire = out_valid_q && wr_ready;
    assign out_free = !out_valid_q || wr_ready;
    // Hold off a read whose returning data could find both the output and skid registers full.
    assign rd_block = out_valid_q && (skid_valid_q || (!wr_ready && in_flight_q));
    assign rd_go    = (state_q == StRun) && !rd_block;
    assign last_rd  = (rd_cnt_q == len_q - One);
    assign last_wr  = (wr_cnt_q == len_q - One);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (len == '0) ? StDone : StRun;
            StRun:   if (rd_go && last_rd) state_d = StDrain;
            StDrain: if (out_fire && last_wr) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        len_d        = len_q;
        a_base_d     = a_base_q;
        b_base_d     = b_base_q;
        d_base_d     = d_base_q;
        rd_cnt_d     = rd_cnt_q;
        ld_cnt_d     = ld_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        in_flight_d  = rd_go;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;

        if (accept) begin
            len_d    = len;
            a_base_d = a_base;
            b_base_d = b_base;
            d_base_d = d_base;
            rd_cnt_d = '0;
            ld_cnt_d = '0;
            wr_cnt_d = '0;
        end
        if (rd_go) rd_cnt_d = rd_cnt_q + One;
        if (out_fire) wr_cnt_d = wr_cnt_q + One;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_flight_q;
                skid_data_d  = prod;
            end else begin
                out_valid_d = in_flight_q;
                if (in_flight_q) out_data_d = prod;
            end
            if (skid_valid_q || in_flight_q) begin
                out_addr_d = d_base_q + ld_cnt_q[ADDR_W-1:0];
                ld_cnt_d   = ld_cnt_q + One;
            end
        end else if (in_flight_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            len_q        <= '0;
            a_base_q     <= '0;
            b_base_q     <= '0;
            d_base_q     <= '0;
            rd_cnt_q     <= '0;
            ld_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            in_flight_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            a_base_q     <= a_base_d;
            b_base_q     <= b_base_d;
            d_base_q     <= d_base_d;
            rd_cnt_q     <= rd_cnt_d;
            ld_cnt_q     <= ld_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            in_flight_q  <= in_flight_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
        end
    end

`ifdef VEC_MULT_SAT_EN
    // Any element returning from memory that clipped marks the command.
    always_comb begin
        sat_d = sat_q;
        if (accept) sat_d = 1'b0;
        else if (in_flight_q && clip) sat_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end

    assign sat_flag = sat_q;
`endif

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign rd_en     = rd_go;
    assign rd_addr_a = a_base_q + rd_cnt_q[ADDR_W-1:0];
    assign rd_addr_b = b_base_q + rd_cnt_q[ADDR_W-1:0];
    assign wr_en     = out_valid_q;
    assign wr_addr   = out_addr_q;
    assign wr_data   = out_data_q;

endmodule
